// File: rtl/swi_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : swi_debouncer
// Purpose  : Synchronises and debounces the board switch vector as a whole.
//            Publishes a stable copy, per-bit rise/fall pulses, a change
//            strobe, and a valid/ack event register with a sticky overrun
//            flag, so an irregularly polling consumer can always tell
//            whether it missed a change.
// Revision : 1.0  initial release
// ============================================================================
module swi_debouncer #(
  parameter int NBITS         = 8,
  parameter int STABLE_CYCLES = 3    // legal range 1..255
) (
  input  logic             clk_2,
  input  logic             reset_n,
  input  logic [NBITS-1:0] SWI,
  output logic [NBITS-1:0] stable,
  output logic [NBITS-1:0] rise,
  output logic [NBITS-1:0] fall,
  output logic             changed,
  output logic             evt_valid,
  output logic [NBITS-1:0] evt_value,
  input  logic             evt_ack,
  output logic             overrun
);

  // Counter target, held in the counter's own 8-bit width.
  localparam logic [7:0] c_STABLE_CNT = 8'(STABLE_CYCLES);

  // Two-flop synchroniser; nothing may sit between the stages.
  logic [NBITS-1:0] r_s1;
  logic [NBITS-1:0] r_s2;

  // Candidate value and the number of consecutive samples it has been seen.
  logic [NBITS-1:0] r_cand;
  logic [7:0]       r_cnt;

  // Debounced value and its change pulses.
  logic [NBITS-1:0] r_stable;
  logic [NBITS-1:0] r_rise;
  logic [NBITS-1:0] r_fall;
  logic             r_changed;

  // Consumer-facing event register.
  logic             r_evt_valid;
  logic [NBITS-1:0] r_evt_value;
  logic             r_overrun;

  // The candidate has survived the full window and differs from what is
  // currently published: this edge commits it.
  logic w_accept;
  // A new sample disagrees with the candidate: restart the window.
  logic w_restart;

  assign w_restart = (r_s2 != r_cand);
  assign w_accept  = (r_cnt == c_STABLE_CNT) && (r_cand != r_stable);

  // Bring the asynchronous switch levels into the clk_2 domain.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= SWI;
      r_s2 <= r_s1;
    end
  end

  // Track how long the synchronised vector has held one value; saturate at
  // the window length so the counter never wraps while the input is quiet.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      r_cand <= '0;
      r_cnt  <= 8'd0;
    end else if (w_restart) begin
      r_cand <= r_s2;
      r_cnt  <= 8'd1;
    end else if (r_cnt < c_STABLE_CNT) begin
      r_cnt  <= r_cnt + 8'd1;
    end
  end

  // Commit an accepted candidate and emit one-cycle edge pulses.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      r_stable  <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end else if (w_accept) begin
      r_stable  <= r_cand;
      r_rise    <= r_cand & ~r_stable;
      r_fall    <= ~r_cand & r_stable;
      r_changed <= 1'b1;
    end else begin
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end
  end

  // Event register: a new accept always wins and carries the newest value;
  // it is an overrun only if the previous event was neither acked this edge
  // nor already consumed. An ack on an accept edge is absorbed by the new
  // event, so evt_valid stays high.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      r_evt_valid <= 1'b0;
      r_evt_value <= '0;
      r_overrun   <= 1'b0;
    end else if (w_accept) begin
      r_evt_valid <= 1'b1;
      r_evt_value <= r_cand;
      if (r_evt_valid && !evt_ack) begin
        r_overrun <= 1'b1;
      end
    end else if (r_evt_valid && evt_ack) begin
      r_evt_valid <= 1'b0;
    end
  end

  assign stable    = r_stable;
  assign rise      = r_rise;
  assign fall      = r_fall;
  assign changed   = r_changed;
  assign evt_valid = r_evt_valid;
  assign evt_value = r_evt_value;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_swi_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_swi_debouncer
// Purpose  : Self-checking bench for swi_debouncer. A queue-based reference
//            model decides acceptance from the last STABLE_CYCLES synchronised
//            samples; directed scenarios are followed by randomised traffic.
// Revision : 1.0  initial release
// ============================================================================
module tb_swi_debouncer;

  localparam int NBITS = 8;
  localparam int S     = 3;

  logic             clk_2   = 1'b0;
  logic             reset_n = 1'b1;
  logic [NBITS-1:0] SWI     = '0;
  logic             evt_ack = 1'b0;
  logic [NBITS-1:0] stable, rise, fall, evt_value;
  logic             changed, evt_valid, overrun;

  int n_cmp = 0;
  int n_err = 0;

  swi_debouncer #(.NBITS(NBITS), .STABLE_CYCLES(S)) dut (
    .clk_2     (clk_2),
    .reset_n   (reset_n),
    .SWI       (SWI),
    .stable    (stable),
    .rise      (rise),
    .fall      (fall),
    .changed   (changed),
    .evt_valid (evt_valid),
    .evt_value (evt_value),
    .evt_ack   (evt_ack),
    .overrun   (overrun)
  );

  always #5 clk_2 = ~clk_2;

  // Reference model state.
  logic [NBITS-1:0] m_pipe[$];   // two-sample delay of SWI
  logic [NBITS-1:0] m_hist[$];   // last S synchronised samples since reset
  logic [NBITS-1:0] m_stable, m_rise, m_fall, m_evv;
  logic             m_changed, m_ev, m_ovr;

  // Model: a value is accepted when the previous S synchronised samples all
  // agree and differ from the published value.
  always @(posedge clk_2 or negedge reset_n) begin : p_model
    logic [NBITS-1:0] y, v;
    bit acc, same;
    if (!reset_n) begin
      m_pipe.delete();
      m_pipe.push_back('0);
      m_pipe.push_back('0);
      m_hist.delete();
      m_stable = '0; m_rise = '0; m_fall = '0; m_evv = '0;
      m_changed = 1'b0; m_ev = 1'b0; m_ovr = 1'b0;
    end else begin
      y = m_pipe.pop_front();
      m_pipe.push_back(SWI);
      acc = 1'b0;
      v   = '0;
      if (m_hist.size() >= S) begin
        v    = m_hist[m_hist.size()-1];
        same = 1'b1;
        for (int i = 0; i < S; i++)
          if (m_hist[m_hist.size()-1-i] != v) same = 1'b0;
        acc = same && (v != m_stable);
      end
      m_rise    = acc ? (v & ~m_stable) : '0;
      m_fall    = acc ? (~v & m_stable) : '0;
      m_changed = acc;
      if (acc && (!m_ev || evt_ack)) begin
        m_ev = 1'b1; m_evv = v;
      end else if (acc) begin
        m_evv = v; m_ovr = 1'b1;
      end else if (m_ev && evt_ack) begin
        m_ev = 1'b0;
      end
      if (acc) m_stable = v;
      m_hist.push_back(y);
      if (m_hist.size() > S) void'(m_hist.pop_front());
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("stable",    32'(stable),    32'(m_stable));
    chk("rise",      32'(rise),      32'(m_rise));
    chk("fall",      32'(fall),      32'(m_fall));
    chk("changed",   32'(changed),   32'(m_changed));
    chk("evt_valid", 32'(evt_valid), 32'(m_ev));
    chk("evt_value", 32'(evt_value), 32'(m_evv));
    chk("overrun",   32'(overrun),   32'(m_ovr));
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_2);
      #1;
      compare_all();
    end
  endtask

  // Assert reset between edges and confirm it acts without a clock.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    compare_all();
    chk("rst_stable",  32'(stable),    32'h0);
    chk("rst_rise",    32'(rise),      32'h0);
    chk("rst_evv",     32'(evt_value), 32'h0);
    chk("rst_valid",   32'(evt_valid), 32'h0);
    chk("rst_overrun", 32'(overrun),   32'h0);
    tick(2);
    reset_n = 1'b1;
  endtask

  initial begin
    #2;
    do_reset();

    // Quiet input after reset.
    SWI = 8'h00;
    tick(10);
    chk("idle_stable", 32'(stable),    32'h0);
    chk("idle_valid",  32'(evt_valid), 32'h0);

    // Clean change, accepted on the sixth edge, then acknowledged.
    SWI = 8'hA5;
    tick(5);
    chk("a5_early", 32'(stable), 32'h0);
    tick();
    chk("a5_stable",  32'(stable),    32'hA5);
    chk("a5_rise",    32'(rise),      32'hA5);
    chk("a5_fall",    32'(fall),      32'h00);
    chk("a5_valid",   32'(evt_valid), 32'h1);
    chk("a5_value",   32'(evt_value), 32'hA5);
    tick();
    chk("a5_pulse_end", 32'(rise), 32'h0);
    evt_ack = 1'b1;
    tick();
    evt_ack = 1'b0;
    chk("a5_acked", 32'(evt_valid), 32'h0);

    // Short bounce is rejected; a held value is accepted once.
    do_reset();
    SWI = 8'h01; tick(2);
    SWI = 8'h00; tick(8);
    chk("bounce_stable", 32'(stable), 32'h0);
    SWI = 8'h01; tick(5);
    chk("bounce_early", 32'(changed), 32'h0);
    tick();
    chk("bounce_rise", 32'(rise), 32'h01);

    // Simultaneous rise and fall on different bits.
    do_reset();
    SWI = 8'hF0; tick(8);
    SWI = 8'h0F; tick(6);
    chk("swap_rise", 32'(rise), 32'h0F);
    chk("swap_fall", 32'(fall), 32'hF0);

    // Unacknowledged event overwritten -> sticky overrun.
    do_reset();
    SWI = 8'h01; tick(8);
    SWI = 8'h03; tick(6);
    chk("ovr_value", 32'(evt_value), 32'h03);
    chk("ovr_flag",  32'(overrun),   32'h1);
    evt_ack = 1'b1; tick(); evt_ack = 1'b0;
    tick(2);
    chk("ovr_sticky", 32'(overrun), 32'h1);

    // Ack coinciding with a new accept keeps the event valid, no overrun.
    do_reset();
    SWI = 8'h01; tick(8);
    SWI = 8'h02; tick(5);
    evt_ack = 1'b1; tick(); evt_ack = 1'b0;
    chk("ackacc_valid", 32'(evt_valid), 32'h1);
    chk("ackacc_value", 32'(evt_value), 32'h02);
    chk("ackacc_ovr",   32'(overrun),   32'h0);
    SWI = 8'h07; tick(2);
    do_reset();

    // Randomised traffic with random acks and occasional resets.
    for (int seg = 0; seg < 250; seg++) begin
      SWI = NBITS'($urandom);
      if ($urandom_range(0, 2) == 0) SWI = stable;
      for (int c = 0; c < int'($urandom_range(1, 7)); c++) begin
        evt_ack = ($urandom_range(0, 3) == 0);
        tick();
      end
      evt_ack = 1'b0;
      if ($urandom_range(0, 49) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
